dpram_stream_reader: RTL and testbench
======================================

# dpram_stream_reader

Read-side streaming engine for the dual-port RAM. On a start command it walks a contiguous, wrapping address range through the RAM's synchronous read port (re, r_addr, r_data, one-cycle read latency) and presents each word on a valid/ready output stream. A small credit-managed buffer absorbs the read latency, so the block sustains one word per cycle under full downstream readiness and loses no data under backpressure. It feeds consumers such as display refresh or the serial transmit path from buffers filled through the RAM's write port.

## Interface
- MEM_WIDTH, 8, data word width; matches the RAM.
- MEM_DEPTH, 1024, RAM depth in words.
- ADDR_WIDTH, $clog2(MEM_DEPTH), RAM address width.
- FIFO_DEPTH, 4, output buffer entries; minimum 3 for full throughput.

Ports:
- rd_clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first address; sampled with start.
- length  in  ADDR_WIDTH+1  word count; sampled with start.
- re  out  1  RAM read enable.
- r_addr  out  ADDR_WIDTH  RAM read address.
- r_data  in  MEM_WIDTH  RAM read data; valid the cycle after re.
- out_data  out  MEM_WIDTH  stream data; equals the buffer head.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse on the final handshake.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start && length!=0 → latch base_addr and length, go to RUN.
  - start && length==0 → pulse done next cycle, stay IDLE, issue no reads.
- RUN: issue a read when the issue counter is nonzero and credit allows. Each issue:
  - r_addr increments modulo MEM_DEPTH (MEM_DEPTH-1 → 0).
  - the issue counter decrements.
  - when the counter reaches 0, go to DRAIN.
- Credit: credit = buffer entries + reads in flight (re cycle plus capture cycle, at most 2). Issue only if credit − (pop this cycle) < FIFO_DEPTH. The buffer never overflows.
- Capture: r_data is written into the buffer in the cycle after each re.
- Output: out_valid = buffer not empty. Pop on out_valid && out_ready. out_data is stable while out_valid && !out_ready.
- DRAIN: when the final word is popped, pulse done and return to IDLE.
- A start pulse while busy is ignored.
- length > MEM_DEPTH is legal: addresses wrap and words repeat.
- Reset at any point clears all state at once, mid-transfer included. Nothing resumes after reset.
- Reset values: re=0, r_addr=0, out_valid=0, out_data=0, busy=0, done=0.

## Timing
- Start accepted in cycle N:
  - re=1 with r_addr=base_addr in N+1.
  - data captured at the end of N+2.
  - out_valid=1 in N+3. Start-to-first-data latency is 3 cycles.
- With out_ready held high, one word per cycle. Last word appears at N+2+length; done is asserted the same cycle.
- busy is high from N+1 through the done cycle inclusive.
- With out_ready low, reads stop after FIFO_DEPTH words are buffered or in flight. Issue resumes the cycle a pop frees credit.
- re is never asserted in IDLE or DRAIN.

## Configuration
- DPRAM_READER_LOOP_EN defined:
  - adds input port loop (1 bit).
  - if loop is high when the last read is issued, the issue counter and r_addr reload from the latched base/length instead of entering DRAIN.
  - the stream continues with no bubble, and done pulses at every pass boundary (final word of each pass popped).
  - loop low ends the transfer after the current pass.
- DPRAM_READER_LOOP_EN undefined: no loop port, single pass only.

## Structure
- Shared package aim65_pkg holds:
  - typedef reader_state_t {IDLE, RUN, DRAIN}.
  - default constants for MEM_WIDTH and MEM_DEPTH, shared with the RAM.
- One sub-module: rd_stream_fifo.
  - synchronous FIFO with FIFO_DEPTH entries.
  - push/pop and an occupancy count.
  - head is registered, with no combinational path from r_data to out_data.
- The top level holds the state machine, address and issue counters, and credit logic.

## Test plan
- Basic read: RAM preloaded with mem[i]=i. base=0x010, length=5, out_ready=1 → out_data 0x10..0x14 in consecutive cycles from N+3; done with 0x14; busy low afterwards.
- Wrap: base=0x3FE, length=4 → r_addr sequence 0x3FE, 0x3FF, 0x000, 0x001; data order preserved.
- Backpressure: length=8 with out_ready toggling 1-0-0-1 → all 8 words delivered in order, no loss or duplication, buffer never exceeds 4 entries, out_data stable while stalled.
- Zero length and busy start:
  - length=0 → done next cycle, re never asserted.
  - start during RUN → ignored; the word count equals the original length.
- Async reset mid-transfer: assert reset after the 3rd word → all outputs zero within the same cycle. A new start with base=0x100, length=2 then yields 0x00, 0x01 from mem[0x100..0x101].
- Loop build (DPRAM_READER_LOOP_EN defined): loop=1, base=0, length=3 → continuous 0,1,2,0,1,2 with done on each 2. Dropping loop → stream ends after the current pass.

Source files
------------

// File: rtl/aim65_pkg.sv
// Shared RAM constants and the stream reader state type.
package aim65_pkg;

  localparam int AIM65_MEM_WIDTH = 8;
  localparam int AIM65_MEM_DEPTH = 1024;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } reader_state_t;

endpackage

// File: rtl/dpram_stream_reader_fifo.sv
// rd_stream_fifo: small synchronous FIFO with a registered head.
// Head is read from the storage array, never straight from din.
module rd_stream_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/dpram_stream_reader.sv
// Streams a wrapping RAM address range onto a valid/ready port.
// Optional repeat mode: DPRAM_READER_LOOP_EN adds the loop input.
module dpram_stream_reader
  import aim65_pkg::*;
#(
  parameter int MEM_WIDTH  = AIM65_MEM_WIDTH,
  parameter int MEM_DEPTH  = AIM65_MEM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  rd_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  re,
  output logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [MEM_WIDTH-1:0]  r_data,
  output logic [MEM_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
`ifdef DPRAM_READER_LOOP_EN
  ,
  input  logic                  loop
`endif
);

  localparam int FW = MEM_WIDTH + 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int KW = CW + 1;

  reader_state_t state_q;
  reader_state_t state_d;

  logic [ADDR_WIDTH:0] cnt_q;
  logic                re_q;
  logic                last_q;
  logic                zero_done_q;
  logic                load;
  logic                zero_start;
  logic                last_issue;
  logic                issue_ok;
  logic                pop;
  logic                head_last;
  logic [FW-1:0]       head;
  logic [CW-1:0]       occ;
  logic                empty;
  logic [KW-1:0]       credit;

`ifdef DPRAM_READER_LOOP_EN
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic                  reload;
`endif

  function automatic logic [ADDR_WIDTH-1:0] addr_next(
    input logic [ADDR_WIDTH-1:0] a
  );
    return (a == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  // Words buffered plus the word landing this cycle, less any pop.
  assign credit = KW'(occ) + KW'(re_q) - KW'(pop);
  assign issue_ok = (credit < KW'(FIFO_DEPTH));

  assign last_issue = (cnt_q == (ADDR_WIDTH + 1)'(1));
  assign out_valid  = !empty;
  assign pop        = out_valid && out_ready;
  assign out_data   = head[MEM_WIDTH-1:0];
  assign head_last  = head[MEM_WIDTH];
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    re         = 1'b0;
    load       = 1'b0;
    zero_start = 1'b0;
    done       = zero_done_q || (pop && head_last);
`ifdef DPRAM_READER_LOOP_EN
    reload     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            load    = 1'b1;
            state_d = RUN;
          end else begin
            zero_start = 1'b1;
          end
        end
      end
      RUN: begin
        re = (cnt_q != '0) && issue_ok;
        if (re && last_issue) begin
`ifdef DPRAM_READER_LOOP_EN
          if (loop) reload = 1'b1;
          else      state_d = DRAIN;
`else
          state_d = DRAIN;
`endif
        end
      end
      DRAIN: begin
        if (pop && head_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      r_addr      <= '0;
      cnt_q       <= '0;
      re_q        <= 1'b0;
      last_q      <= 1'b0;
      zero_done_q <= 1'b0;
`ifdef DPRAM_READER_LOOP_EN
      base_q      <= '0;
      len_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      re_q        <= re;
      last_q      <= re && last_issue;
      zero_done_q <= zero_start;
      if (load) begin
        r_addr <= base_addr;
        cnt_q  <= length;
`ifdef DPRAM_READER_LOOP_EN
        base_q <= base_addr;
        len_q  <= length;
      end else if (reload) begin
        r_addr <= base_q;
        cnt_q  <= len_q;
`endif
      end else if (re) begin
        r_addr <= addr_next(r_addr);
        cnt_q  <= cnt_q - 1'b1;
      end
    end
  end

  // Each entry carries a pass-end tag so done lines up with its word.
  rd_stream_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (rd_clk),
    .reset (reset),
    .push  (re_q),
    .din   ({last_q, r_data}),
    .pop   (pop),
    .dout  (head),
    .count (occ),
    .empty (empty)
  );

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Scoreboard bench for dpram_stream_reader with a behavioural RAM.
module tb_dpram_stream_reader;
  import aim65_pkg::*;

  localparam int AW = 10;
  localparam int W  = 8;
  localparam int FD = 4;

  logic          rd_clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          re;
  logic [AW-1:0] r_addr;
  logic [W-1:0]  r_data = '0;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;
  logic          done;
`ifdef DPRAM_READER_LOOP_EN
  logic          loop = 1'b0;
`endif

  always #5 rd_clk = ~rd_clk;

  dpram_stream_reader dut (
    .rd_clk    (rd_clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .re        (re),
    .r_addr    (r_addr),
    .r_data    (r_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
`ifdef DPRAM_READER_LOOP_EN
    .done      (done),
    .loop      (loop)
`else
    .done      (done)
`endif
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic [7:0]    ram [1024];
  exp_t          exp_q [$];
  logic [AW-1:0] addr_q [$];
  exp_t          e;

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   re_cnt = 0;
  int   pop_cnt = 0;
  int   done_cnt = 0;
  int   outst = 0;
  int   max_outst = 0;
  int   first_cyc = 0;
  int   done_cyc = 0;
  int   bp_ph = 0;
  bit   arm = 0;
  bit   log_addr = 0;
  bit   bp_mode = 0;
  bit   prev_stall = 0;
  logic [7:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  always @(posedge rd_clk) cyc <= cyc + 1;

  always @(posedge rd_clk) if (re) r_data <= ram[r_addr];

  initial begin
    forever begin
      @(posedge rd_clk);
      #1;
      if (bp_mode) begin
        out_ready = (bp_ph % 4 == 0) || (bp_ph % 4 == 3);
        bp_ph++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  always @(negedge rd_clk) begin
    if (!reset) begin
      if (re) begin
        re_cnt++;
        if (log_addr) addr_q.push_back(r_addr);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid && arm) begin
        first_cyc = cyc;
        arm = 0;
      end
      if (prev_stall && out_valid) chk("stall_hold", 32'(out_data), 32'(prev_data));
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          chk("extra_word", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("data", 32'(out_data), 32'(e.data));
          chk("done_tag", 32'(done), 32'(e.last));
        end
      end
      outst = outst + int'(re) - int'(out_valid && out_ready);
      if (outst > max_outst) max_outst = outst;
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic push_pass(input logic [AW-1:0] b, input int l);
    for (int i = 0; i < l; i++) begin
      exp_t x;
      x.data = ram[(int'(b) + i) % 1024];
      x.last = (i == l - 1);
      exp_q.push_back(x);
    end
  endtask

  task automatic kick(input logic [AW-1:0] b, input int l, input bit expect_it);
    @(posedge rd_clk);
    #1;
    if (expect_it) push_pass(b, l);
    start = 1'b1;
    base_addr = b;
    length = (AW + 1)'(l);
    t0 = cyc;
    arm = expect_it;
    @(posedge rd_clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_empty(input string tag, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge rd_clk);
      k++;
    end
    chk({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge rd_clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, r0, p0, k;
    logic [AW-1:0] wexp [4];
    wexp[0] = 10'h3FE;
    wexp[1] = 10'h3FF;
    wexp[2] = 10'h000;
    wexp[3] = 10'h001;
    for (int i = 0; i < 1024; i++) ram[i] = i[7:0];

    repeat (2) @(posedge rd_clk);
    @(negedge rd_clk);
    chk("rst_re", 32'(re), 0);
    chk("rst_r_addr", 32'(r_addr), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    @(posedge rd_clk);
    #1 reset = 1'b0;

    d0 = done_cnt;
    kick(10'h010, 5, 1);
    wait_empty("basic", 50);
    chk("basic_latency", 32'(first_cyc - t0), 32'd3);
    chk("basic_done_cyc", 32'(done_cyc - t0), 32'd7);
    chk("basic_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("basic_busy_after", 32'(busy), 0);

    addr_q.delete();
    log_addr = 1;
    kick(10'h3FE, 4, 1);
    wait_empty("wrap", 50);
    log_addr = 0;
    chk("wrap_reads", 32'(addr_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < addr_q.size(); i++)
      chk("wrap_addr", 32'(addr_q[i]), 32'(wexp[i]));

    max_outst = 0;
    bp_mode = 1;
    kick(10'h080, 8, 1);
    wait_empty("bp", 200);
    bp_mode = 0;
    chk("bp_credit_bound", 32'(max_outst <= FD), 32'd1);
    chk("bp_busy_after", 32'(busy), 0);

    r0 = re_cnt;
    d0 = done_cnt;
    kick(10'h055, 0, 0);
    @(negedge rd_clk);
    chk("zero_done", 32'(done), 32'd1);
    @(negedge rd_clk);
    chk("zero_done_pulse", 32'(done), 0);
    chk("zero_no_re", 32'(re_cnt - r0), 0);
    chk("zero_busy", 32'(busy), 0);

    p0 = pop_cnt;
    d0 = done_cnt;
    kick(10'h020, 6, 1);
    repeat (2) @(posedge rd_clk);
    #1;
    start = 1'b1;
    base_addr = 10'h200;
    length = 11'd3;
    @(posedge rd_clk);
    #1 start = 1'b0;
    wait_empty("busy_start", 60);
    repeat (4) @(negedge rd_clk);
    chk("busy_start_words", 32'(pop_cnt - p0), 32'd6);
    chk("busy_start_done", 32'(done_cnt - d0), 32'd1);

    p0 = pop_cnt;
    kick(10'h040, 10, 1);
    k = 0;
    while (pop_cnt - p0 < 3 && k < 50) begin
      @(negedge rd_clk);
      k++;
    end
    chk("rst_mid_reached", 32'(pop_cnt - p0 >= 3), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_re", 32'(re), 0);
    chk("rst_mid_r_addr", 32'(r_addr), 0);
    chk("rst_mid_valid", 32'(out_valid), 0);
    chk("rst_mid_data", 32'(out_data), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_done", 32'(done), 0);
    exp_q.delete();
    outst = 0;
    prev_stall = 0;
    arm = 0;
    repeat (2) @(posedge rd_clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge rd_clk);
    chk("rst_nothing_resumes", 32'(out_valid | busy), 0);
    d0 = done_cnt;
    kick(10'h100, 2, 1);
    wait_empty("post_rst", 50);
    chk("post_rst_done", 32'(done_cnt - d0), 32'd1);

`ifdef DPRAM_READER_LOOP_EN
    r0 = re_cnt;
    d0 = done_cnt;
    loop = 1'b1;
    kick(10'h000, 3, 1);
    push_pass(10'h000, 3);
    k = 0;
    while (re_cnt - r0 < 4 && k < 50) begin
      @(negedge rd_clk);
      k++;
    end
    loop = 1'b0;
    wait_empty("loop", 80);
    chk("loop_reads", 32'(re_cnt - r0), 32'd6);
    chk("loop_done_cnt", 32'(done_cnt - d0), 32'd2);
    chk("loop_busy_after", 32'(busy), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
